dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Memory-stage load/store access unit between the pipeline's memory stage and the word-wide data memory. It uses the memory's word address, word write-enable and asynchronous read to provide ARMv4 byte and halfword accesses:
- Loads: lane extraction plus zero or sign extension, and rotation of unaligned word loads.
- Sub-word stores: a two-cycle read-modify-write that stalls the pipeline for one cycle.

## Interface
- ROTATE_UNALIGNED, 1, when 1 a word load at addr[1:0]≠0 returns the aligned word rotated right by 8·addr[1:0]; when 0 the aligned word is returned unrotated.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  memory-stage access valid this cycle.
- we_in  in  1  1 = store, 0 = load (meaningful only when req=1).
- size  in  2  00 word, 01 byte, 10 halfword, 11 treated as word.
- sign  in  1  sign-extend byte/halfword loads; ignored for stores and word loads.
- addr  in  32  byte address.
- wdata  in  32  store data; byte uses [7:0], halfword uses [15:0].
- rdata  out  32  formatted load result.
- stall  out  1  hold memory stage and all earlier stages.
- dmem_a  out  32  word-aligned address to data memory.
- dmem_we  out  1  data memory write enable.
- dmem_wd  out  32  data memory write data.
- dmem_rd  in  32  data memory asynchronous read data for dmem_a.

## Operation
- Byte order is little-endian: byte lane = addr[1:0], halfword lane = addr[1]. addr[0] is ignored for halfwords; addr[1:0] is ignored for word stores.
- dmem_a = {addr[31:2],2'b00} in IDLE and {addr_q[31:2],2'b00} in MERGE.
- rdata is formatted combinationally from dmem_rd every cycle, whether or not the access is a load:
  - byte: lane selected, then zero- or sign-extended.
  - halfword: lane selected, then zero- or sign-extended.
  - word: rotated or not per ROTATE_UNALIGNED.
- FSM states: IDLE, MERGE.
- IDLE, req=0 or load: dmem_we=0, stall=0; stay in IDLE.
- IDLE, word store: dmem_we=1, dmem_wd=wdata, stall=0; stay in IDLE (single cycle).
- IDLE, byte/half store:
  - Outputs: dmem_we=0, stall=1.
  - On the clock edge: merge_q ← dmem_rd with the target lane replaced by wdata's low byte/halfword; addr_q ← addr; go to MERGE.
- MERGE:
  - Outputs: dmem_we=1, dmem_wd=merge_q, stall=0; the write lands at the edge ending MERGE.
  - Next state: IDLE unconditionally.
  - The write is committed: it completes from merge_q and addr_q regardless of req, we_in, addr or wdata during MERGE.
- Back-to-back sub-word stores each take IDLE→MERGE (2 cycles). The request presented after MERGE is a new request and is not re-triggered.
- Reset (asynchronous, any state, including mid-MERGE):
  - state←IDLE, merge_q←0, addr_q←0.
  - dmem_we and stall are forced to 0 while reset is high, so no partial write occurs.

## Timing
- Load latency: 0 cycles. rdata is valid in the same cycle as addr, through the memory's asynchronous read.
- Word store: 1 cycle, no stall.
- Sub-word store: 2 cycles. stall is high for exactly the first cycle; the memory write occurs at the second rising edge.
- Reset values: stall=0, dmem_we=0, dmem_wd=0, state=IDLE. rdata follows dmem_rd at address {addr[31:2],2'b00}.
- No combinational path from dmem_rd to dmem_we or stall; stall depends only on state, req, we_in, size and reset.

## Test plan
- Reset: hold reset high with req=1, we_in=1, size=01 → stall=0, dmem_we=0; after release the first cycle is IDLE behaviour.
- Word store, then load:
  - STR 0xDEADBEEF to 0x100 → dmem_we=1 in the same cycle, stall=0.
  - Next cycle LDR 0x100 → rdata=0xDEADBEEF.
- STRB:
  - Memory word at 0x100 = 0x11223344; STRB wdata=0x000000AB to 0x102.
  - Cycle 1: stall=1, dmem_we=0.
  - Cycle 2: dmem_we=1, dmem_wd=0x11AB3344, stall=0.
  - STRH 0xBEEF to 0x102 then yields 0xBEEF3344.
- Sub-word loads from word 0x80FF7F01 at 0x100:
  - LDRSB 0x103 → 0xFFFFFF80.
  - LDRB 0x103 → 0x00000080.
  - LDRSH 0x102 → 0xFFFF80FF.
  - LDRH 0x100 → 0x00007F01.
- Unaligned LDR, ROTATE_UNALIGNED=1, word 0x11223344 at 0x100:
  - addr 0x101 → 0x44112233.
  - addr 0x103 → 0x22334411.
  - With ROTATE_UNALIGNED=0, addr 0x101 → 0x11223344.
- Reset during MERGE of an STRB → dmem_we=0 throughout, memory word unchanged, state IDLE after release.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store unit: formats byte/halfword/word loads from a word-wide
// asynchronous-read memory and turns sub-word stores into a two-cycle read-modify-write.
module dmem_access_unit #(
    parameter bit ROTATE_UNALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we_in,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic [31:0] dmem_a,
    output logic        dmem_we,
    output logic [31:0] dmem_wd,
    input  logic [31:0] dmem_rd
);

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_merge_q;
    logic [31:2] r_addr_q;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_sub_store;
    logic        w_word_store;
    logic        w_start_merge;
    logic [31:0] w_merged;

    function automatic logic [31:0] fmt_load(
        input logic [31:0] rd,
        input logic [1:0]  sz,
        input logic        sgn,
        input logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [63:0] dbl;
        b   = rd[{lane, 3'b000} +: 8];
        h   = lane[1] ? rd[31:16] : rd[15:0];
        dbl = {rd, rd} >> {lane, 3'b000};
        case (sz)
            SZ_BYTE: fmt_load = {{24{sgn & b[7]}}, b};
            SZ_HALF: fmt_load = {{16{sgn & h[15]}}, h};
            default: fmt_load = ROTATE_UNALIGNED ? dbl[31:0] : rd;
        endcase
    endfunction

    // Replace only the addressed lane of the current memory word with the store data.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] rd,
        input logic [31:0] wd,
        input logic [1:0]  sz,
        input logic [1:0]  lane
    );
        logic [31:0] m;
        m = rd;
        if (sz == SZ_BYTE) begin
            m[{lane, 3'b000} +: 8] = wd[7:0];
        end else if (lane[1]) begin
            m[31:16] = wd[15:0];
        end else begin
            m[15:0] = wd[15:0];
        end
        merge_lane = m;
    endfunction

    assign w_is_byte    = (size == SZ_BYTE);
    assign w_is_half    = (size == SZ_HALF);
    assign w_sub_store  = req & we_in & (w_is_byte | w_is_half);
    assign w_word_store = req & we_in & ~(w_is_byte | w_is_half);
    assign w_merged     = merge_lane(dmem_rd, wdata, size, addr[1:0]);
    assign rdata        = fmt_load(dmem_rd, size, sign, addr[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_merge_q <= '0;
            r_addr_q  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start_merge) begin
                r_merge_q <= w_merged;
                r_addr_q  <= addr[31:2];
            end
        end
    end

    // MERGE ignores the live request: the write always completes from the captured state.
    always_comb begin
        w_next_state  = r_state;
        w_start_merge = 1'b0;
        stall         = 1'b0;
        dmem_we       = 1'b0;
        dmem_wd       = '0;
        dmem_a        = {addr[31:2], 2'b00};
        case (r_state)
            ST_IDLE: begin
                if (w_sub_store) begin
                    stall         = 1'b1;
                    w_start_merge = 1'b1;
                    w_next_state  = ST_MERGE;
                end else if (w_word_store) begin
                    dmem_we = 1'b1;
                    dmem_wd = wdata;
                end
            end
            ST_MERGE: begin
                dmem_a       = {r_addr_q, 2'b00};
                dmem_we      = 1'b1;
                dmem_wd      = r_merge_q;
                w_next_state = ST_IDLE;
            end
        endcase
        if (reset) begin
            stall   = 1'b0;
            dmem_we = 1'b0;
            dmem_wd = '0;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: behavioural word memory, scoreboard of expected load
// results and write data, one task per scenario.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we_in = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata, rdata_nr;
    logic        stall, stall_nr;
    logic [31:0] dmem_a, dmem_a_nr;
    logic        dmem_we, dmem_we_nr;
    logic [31:0] dmem_wd, dmem_wd_nr;
    logic [31:0] dmem_rd, dmem_rd_nr;

    logic [31:0] mem [0:255];

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign dmem_rd    = mem[dmem_a[9:2]];
    assign dmem_rd_nr = mem[dmem_a_nr[9:2]];

    always @(posedge clk) begin
        if (dmem_we) mem[dmem_a[9:2]] <= dmem_wd;
    end

    dmem_access_unit #(.ROTATE_UNALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .req(req), .we_in(we_in), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .dmem_a(dmem_a),
        .dmem_we(dmem_we), .dmem_wd(dmem_wd), .dmem_rd(dmem_rd)
    );

    dmem_access_unit #(.ROTATE_UNALIGNED(1'b0)) dut_nr (
        .clk(clk), .reset(reset), .req(req), .we_in(we_in), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata_nr), .stall(stall_nr), .dmem_a(dmem_a_nr),
        .dmem_we(dmem_we_nr), .dmem_wd(dmem_wd_nr), .dmem_rd(dmem_rd_nr)
    );

    task automatic sb_push(input string name, input logic [31:0] val);
        exp_t x;
        x.name = name;
        x.val  = val;
        exp_q.push_back(x);
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req   = r;
        we_in = w;
        size  = sz;
        sign  = sg;
        addr  = a;
        wdata = d;
    endtask

    task automatic test_reset;
        mem[8'h40] = 32'h80FF7F01;
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h100, 32'h000000AB);
        sb_push("reset_rdata", 32'h00000001);
        #2;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_tests++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", dmem_we); end
        n_tests++; if (dmem_wd !== 32'h0) begin n_fail++; $display("FAIL reset_wd: got %h expected 0", dmem_wd); end
        e = exp_q.pop_front();
        n_tests++; if (rdata !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rdata, e.val); end
        @(negedge clk);
        reset = 1'b0;
        #2;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL post_reset_stall: got %b expected 1", stall); end
        n_tests++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL post_reset_we: got %b expected 0", dmem_we); end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        sb_push("post_reset_wd", 32'h80FF7FAB);
        #2;
        e = exp_q.pop_front();
        n_tests++; if (dmem_we !== 1'b1 || dmem_wd !== e.val) begin n_fail++; $display("FAIL %s: got we=%b wd=%h expected we=1 wd=%h", e.name, dmem_we, dmem_wd, e.val); end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_word_store;
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h102, 32'hDEADBEEF);
        sb_push("str_wd", 32'hDEADBEEF);
        #2;
        e = exp_q.pop_front();
        n_tests++; if (dmem_we !== 1'b1 || stall !== 1'b0 || dmem_wd !== e.val || dmem_a !== 32'h100) begin
            n_fail++; $display("FAIL %s: got we=%b stall=%b wd=%h a=%h expected we=1 stall=0 wd=%h a=00000100", e.name, dmem_we, stall, dmem_wd, dmem_a, e.val);
        end
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
        sb_push("ldr_after_str", 32'hDEADBEEF);
        #2;
        e = exp_q.pop_front();
        n_tests++; if (rdata !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rdata, e.val); end
        n_tests++; if (dmem_we !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL ldr_ctrl: got we=%b stall=%b expected 0 0", dmem_we, stall); end
    endtask

    task automatic test_substore(input string name, input logic [1:0] sz, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] exp_word);
        drive(1'b1, 1'b1, sz, 1'b0, a, d);
        sb_push(name, exp_word);
        #2;
        n_tests++; if (stall !== 1'b1 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL %s_c1: got stall=%b we=%b expected 1 0", name, stall, dmem_we); end
        // unrelated request during MERGE must not disturb the committed write
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'hFFFFFFFF);
        #2;
        e = exp_q.pop_front();
        n_tests++; if (dmem_we !== 1'b1 || stall !== 1'b0 || dmem_wd !== e.val || dmem_a !== {a[31:2], 2'b00}) begin
            n_fail++; $display("FAIL %s_c2: got we=%b stall=%b wd=%h a=%h expected we=1 stall=0 wd=%h", e.name, dmem_we, stall, dmem_wd, dmem_a, e.val);
        end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #2;
        n_tests++; if (mem[a[9:2]] !== exp_word) begin n_fail++; $display("FAIL %s_mem: got %h expected %h", name, mem[a[9:2]], exp_word); end
    endtask

    task automatic test_strb_strh;
        mem[8'h40] = 32'h11223344;
        mem[8'h00] = 32'h5A5A5A5A;
        test_substore("strb", 2'b01, 32'h102, 32'h000000AB, 32'h11AB3344);
        test_substore("strh", 2'b10, 32'h102, 32'h1234BEEF, 32'hBEEF3344);
        test_substore("strh_lo_odd", 2'b10, 32'h101, 32'h0000CAFE, 32'hBEEFCAFE);
        n_tests++; if (mem[8'h00] !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL merge_ignored_req: got %h expected 5a5a5a5a", mem[8'h00]); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a2;
        mem[8'h41] = 32'h00000000;
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h104, 32'h55);
        #2;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_s1: got stall=%b expected 1", stall); end
        a2 = 32'h105;
        drive(1'b1, 1'b1, 2'b01, 1'b0, a2, 32'h66);
        #2;
        n_tests++; if (stall !== 1'b0 || dmem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_m1: got stall=%b we=%b expected 0 1", stall, dmem_we); end
        drive(1'b1, 1'b1, 2'b01, 1'b0, a2, 32'h66);
        sb_push("b2b_wd2", 32'h00006655);
        #2;
        n_tests++; if (stall !== 1'b1 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_s2: got stall=%b we=%b expected 1 0", stall, dmem_we); end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #2;
        e = exp_q.pop_front();
        n_tests++; if (dmem_we !== 1'b1 || dmem_wd !== e.val) begin n_fail++; $display("FAIL %s: got we=%b wd=%h expected 1 %h", e.name, dmem_we, dmem_wd, e.val); end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #2;
        n_tests++; if (stall !== 1'b0 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got stall=%b we=%b expected 0 0", stall, dmem_we); end
        n_tests++; if (mem[8'h41] !== 32'h00006655) begin n_fail++; $display("FAIL b2b_mem: got %h expected 00006655", mem[8'h41]); end
    endtask

    task automatic test_loads;
        logic [31:0] la [8] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h100, 32'h101, 32'h103};
        logic [1:0]  ls [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
        logic        lg [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] lx [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                                32'h00007F01, 32'h00000001, 32'h0000007F, 32'h000080FF};
        mem[8'h40] = 32'h80FF7F01;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, ls[i], lg[i], la[i], 32'h0);
            sb_push($sformatf("load%0d", i), lx[i]);
            #2;
            e = exp_q.pop_front();
            n_tests++; if (rdata !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rdata, e.val); end
        end
    endtask

    task automatic test_unaligned;
        logic [31:0] ua [5] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h101};
        logic [1:0]  us [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
        logic [31:0] ux [5] = '{32'h44112233, 32'h22334411, 32'h33441122, 32'h11223344, 32'h44112233};
        mem[8'h40] = 32'h11223344;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, us[i], 1'b1, ua[i], 32'h0);
            sb_push($sformatf("ldr_rot%0d", i), ux[i]);
            sb_push($sformatf("ldr_norot%0d", i), 32'h11223344);
            #2;
            e = exp_q.pop_front();
            n_tests++; if (rdata !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rdata, e.val); end
            e = exp_q.pop_front();
            n_tests++; if (rdata_nr !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rdata_nr, e.val); end
        end
    endtask

    task automatic test_reset_merge;
        mem[8'h42] = 32'hCAFEF00D;
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h109, 32'h77);
        #2;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rstm_s1: got stall=%b expected 1", stall); end
        @(negedge clk);
        reset = 1'b1;
        #2;
        n_tests++; if (dmem_we !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rstm_mid: got we=%b stall=%b expected 0 0", dmem_we, stall); end
        @(negedge clk);
        n_tests++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL rstm_hold: got we=%b expected 0", dmem_we); end
        req = 1'b0;
        reset = 1'b0;
        #2;
        n_tests++; if (mem[8'h42] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rstm_mem: got %h expected cafef00d", mem[8'h42]); end
        n_tests++; if (dmem_we !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rstm_idle: got we=%b stall=%b expected 0 0", dmem_we, stall); end
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h109, 32'h77);
        #2;
        n_tests++; if (stall !== 1'b1 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL rstm_restart: got stall=%b we=%b expected 1 0", stall, dmem_we); end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #2;
        n_tests++; if (mem[8'h42] !== 32'hCAFE770D) begin n_fail++; $display("FAIL rstm_after: got %h expected cafe770d", mem[8'h42]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_word_store();
        test_strb_strh();
        test_back_to_back();
        test_loads();
        test_unaligned();
        test_reset_merge();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
